bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_if.sv | 16 +
 rtl/bin2bcd_seq.sv | 97 +++++++++
 tb/tb_bin2bcd_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns status and the packed BCD result.
interface bin2bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one correct-and-shift step per clock, BIN_W steps
// per conversion, result registers updated only on the edge that enters DONE.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   work_reg;
    logic               ovf_work_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic               ovf_reg;

    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   work_next;
    logic               ovf_next;

    // Correct every digit before the shift so no digit exceeds 9 afterwards.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign corr[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                     (work_reg[4*gi +: 4] + 4'd3) :
                                      work_reg[4*gi +: 4];
        end
    endgenerate

    // The bit leaving the top digit is lost, so the chain holds operand mod 10^DIGITS.
    assign work_next = {corr[BCD_W-2:0], bin_reg[BIN_W-1]};
    assign ovf_next  = ovf_work_reg | corr[BCD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            work_reg     <= '0;
            ovf_work_reg <= 1'b0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bcd_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        bin_reg      <= bus.bin;
                        work_reg     <= '0;
                        ovf_work_reg <= 1'b0;
                        cnt_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg     <= work_next;
                    ovf_work_reg <= ovf_next;
                    bin_reg      <= bin_reg << 1;
                    cnt_reg      <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(BIN_W - 1)) begin
                        bcd_reg   <= work_next;
                        ovf_reg   <= ovf_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.bcd      = bcd_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three configurations (8/3, 14/4, 8/2) sharing clock and reset.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cur = 0;
    logic        start_d = 1'b0;
    logic [31:0] bin_d = '0;

    bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) ia ();
    bin2bcd_if #(.BIN_W(14), .DIGITS(4)) ib ();
    bin2bcd_if #(.BIN_W(8),  .DIGITS(2)) ic ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) ua (.clk(clk), .rst(rst), .bus(ia));
    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) ub (.clk(clk), .rst(rst), .bus(ib));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) uc (.clk(clk), .rst(rst), .bus(ic));

    assign ia.start = (cur == 0) && start_d;
    assign ib.start = (cur == 1) && start_d;
    assign ic.start = (cur == 2) && start_d;
    assign ia.bin   = bin_d[7:0];
    assign ib.bin   = bin_d[13:0];
    assign ic.bin   = bin_d[7:0];

    logic        cur_done, cur_busy, cur_ovf;
    logic [15:0] cur_bcd;
    assign cur_done = (cur == 0) ? ia.done : (cur == 1) ? ib.done : ic.done;
    assign cur_busy = (cur == 0) ? ia.busy : (cur == 1) ? ib.busy : ic.busy;
    assign cur_ovf  = (cur == 0) ? ia.overflow : (cur == 1) ? ib.overflow : ic.overflow;
    assign cur_bcd  = (cur == 0) ? {4'h0, ia.bcd} : (cur == 1) ? ib.bcd : {8'h00, ic.bcd};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next done pulse; returns cycles waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!cur_done && n < 200);
    endtask

    task automatic no_done(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (cur_done) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    // One full conversion: accept, scramble bin mid-flight, measure latency and results.
    task automatic convert(input int sel, input logic [31:0] v, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input int exp_lat, input string tag);
        int lat = 0;
        logic stable = 1'b1;
        logic [15:0] b0;
        cur = sel;
        bin_d = v;
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        bin_d = ~v;
        b0 = cur_bcd;
        while (!cur_done && lat < 200) begin
            if (!cur_busy || cur_bcd !== b0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " bcd"}, {16'h0, cur_bcd}, {16'h0, exp_bcd});
        check({tag, " ovf"}, {31'b0, cur_ovf}, {31'b0, exp_ovf});
        check({tag, " busy_at_done"}, {31'b0, cur_busy}, 32'd0);
        check({tag, " hold_in_shift"}, {31'b0, stable}, 32'd1);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, {31'b0, cur_done}, 32'd0);
        $display("convert %s: bin=%0d bcd=%0h ovf=%0b latency=%0d", tag, v, cur_bcd, cur_ovf, lat);
    endtask

    initial begin
        int n;
        #1;
        check("reset busy", {31'b0, ia.busy}, 32'd0);
        check("reset done", {31'b0, ia.done}, 32'd0);
        check("reset bcd",  {20'b0, ia.bcd}, 32'd0);
        check("reset ovf",  {31'b0, ia.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        convert(0, 255,  16'h0255, 1'b0, 8,  "a255");
        convert(0, 0,    16'h0000, 1'b0, 8,  "a0");
        convert(0, 9,    16'h0009, 1'b0, 8,  "a9");
        convert(1, 9999, 16'h9999, 1'b0, 14, "b9999");
        convert(2, 200,  16'h0000, 1'b1, 8,  "c200");
        convert(2, 99,   16'h0099, 1'b0, 8,  "c99");

        // A second start during SHIFT must be dropped.
        cur = 0; bin_d = 123; start_d = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        repeat (2) @(posedge clk);
        #1; bin_d = 45; start_d = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        wait_done(n);
        check("ignore bcd", {16'h0, cur_bcd}, 32'h123);
        no_done("ignore single_done", 14);
        $display("ignore: bcd=%0h", cur_bcd);

        // Start held high: conversions repeat every BIN_W+2 cycles.
        cur = 0; bin_d = 58; start_d = 1'b1;
        wait_done(n);
        check("b2b first bcd", {16'h0, cur_bcd}, 32'h058);
        wait_done(n);
        check("b2b period", n, 10);
        start_d = 1'b0;
        no_done("b2b stops", 14);
        $display("back2back: period=%0d bcd=%0h", n, cur_bcd);

        // Reset during SHIFT cycle 4 aborts the conversion immediately.
        cur = 0; bin_d = 200; start_d = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort bcd",  {20'b0, ia.bcd}, 32'd0);
        check("abort busy", {31'b0, ia.busy}, 32'd0);
        check("abort done", {31'b0, ia.done}, 32'd0);
        check("abort ovf",  {31'b0, ia.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        no_done("abort no_done", 12);
        $display("abort: bcd=%0h busy=%0b", ia.bcd, ia.busy);
        convert(0, 77, 16'h0077, 1'b0, 8, "a77_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
